// File: rtl/semaphore_pkg.sv
// Shared types, default timing and phase-selection helper for the traffic-light controller.
package semaphore_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_e;

    localparam int unsigned DEF_N_PHASES = 2;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_GREEN_T  = 5;
    localparam int unsigned DEF_YELLOW_T = 2;
    localparam int unsigned DEF_ALLRED_T = 1;
    localparam int unsigned DEF_FLASH_T  = 1;
    localparam int unsigned MAX_PHASES   = 32;

    // First requester after cur (cur itself checked last); plain round robin when nobody asks.
    function automatic int unsigned next_phase(input int unsigned cur,
                                               input logic [MAX_PHASES-1:0] req,
                                               input int unsigned n);
        int unsigned nxt;
        int unsigned idx;
        logic        found;
        nxt   = (cur + 1 >= n) ? 0 : cur + 1;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_PHASES; i++) begin
            if (!found && i <= n) begin
                idx = cur + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) begin
                    nxt   = idx;
                    found = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/semaphore_ctrl_tick_timer.sv
// Loadable down-counter advanced by the external tick strobe; zero flags expiry.
module tick_timer #(
    parameter int unsigned          CNT_W   = 8,
    parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/semaphore_ctrl.sv
// N-phase round-robin traffic-light controller with demand skipping and flashing-yellow maintenance mode.
module semaphore_ctrl
    import semaphore_pkg::*;
#(
    parameter int unsigned N_PHASES = DEF_N_PHASES,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned GREEN_T  = DEF_GREEN_T,
    parameter int unsigned YELLOW_T = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T = DEF_ALLRED_T,
    parameter int unsigned FLASH_T  = DEF_FLASH_T,
    localparam int unsigned PW      = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                res,
    input  logic                tick,
    input  logic                dis,
    input  logic [N_PHASES-1:0] req,
    output logic [N_PHASES-1:0] red,
    output logic [N_PHASES-1:0] yel,
    output logic [N_PHASES-1:0] grn,
    output logic [PW-1:0]       phase,
    output logic                flashing
);

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_T - 1);
    localparam logic [PW-1:0]    LAST_PH   = PW'(N_PHASES - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic                flash_on_q, flash_on_d;
    logic [N_PHASES-1:0] red_q, red_d, yel_q, yel_d, grn_q, grn_d;
    logic                flashing_q;
    logic                tmr_load, tmr_zero, expire;
    logic [CNT_W-1:0]    tmr_val;

    tick_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_ALLRED)
    ) u_timer (
        .clk      (clk),
        .res      (res),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .zero     (tmr_zero)
    );

    assign expire = tick && tmr_zero;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        flash_on_d = flash_on_q;
        tmr_load   = 1'b0;
        tmr_val    = LD_ALLRED;
        if (dis) begin
            if (state_q != ST_FLASH) begin
                state_d    = ST_FLASH;
                flash_on_d = 1'b1;
                tmr_load   = 1'b1;
                tmr_val    = LD_FLASH;
            end else if (expire) begin
                flash_on_d = !flash_on_q;
                tmr_load   = 1'b1;
                tmr_val    = LD_FLASH;
            end
        end else begin
            unique case (state_q)
                ST_ALLRED: if (expire) begin
                    state_d  = ST_GREEN;
                    phase_d  = PW'(next_phase(32'(phase_q), MAX_PHASES'(req), N_PHASES));
                    tmr_load = 1'b1;
                    tmr_val  = LD_GREEN;
                end
                ST_GREEN: if (expire) begin
                    state_d  = ST_YELLOW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_YELLOW;
                end
                ST_YELLOW: if (expire) begin
                    state_d  = ST_ALLRED;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ALLRED;
                end
                ST_FLASH: begin
                    state_d    = ST_ALLRED;
                    phase_d    = LAST_PH;
                    flash_on_d = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_ALLRED;
                end
                default: state_d = ST_ALLRED;
            endcase
        end
    end

    // Lamps decode from next state so the registered outputs line up with the state register.
    always_comb begin
        red_d = '1;
        yel_d = '0;
        grn_d = '0;
        unique case (state_d)
            ST_GREEN: begin
                grn_d[phase_d] = 1'b1;
                red_d[phase_d] = 1'b0;
            end
            ST_YELLOW: begin
                yel_d[phase_d] = 1'b1;
                red_d[phase_d] = 1'b0;
            end
            ST_FLASH: begin
                red_d = '0;
                yel_d = {N_PHASES{flash_on_d}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_ALLRED;
            phase_q    <= LAST_PH;
            flash_on_q <= 1'b0;
            red_q      <= '1;
            yel_q      <= '0;
            grn_q      <= '0;
            flashing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            flash_on_q <= flash_on_d;
            red_q      <= red_d;
            yel_q      <= yel_d;
            grn_q      <= grn_d;
            flashing_q <= (state_d == ST_FLASH);
        end
    end

    assign red      = red_q;
    assign yel      = yel_q;
    assign grn      = grn_q;
    assign phase    = phase_q;
    assign flashing = flashing_q;

endmodule

// File: tb/tb_semaphore_ctrl.sv
// Directed scoreboard bench for semaphore_ctrl across three parameter sets (N=2 default, N=4, N=3 fast).
module tb_semaphore_ctrl;

    typedef struct {
        int         sel;
        string      tag;
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic [1:0] ph;
        logic       fl;
    } exp_t;

    logic clk = 1'b0;
    logic res, tick, dis;
    logic [1:0] req2;
    logic [3:0] req4;
    logic [2:0] req3;

    logic [1:0] red2, yel2, grn2;
    logic [0:0] phase2;
    logic       fl2;
    logic [3:0] red4, yel4, grn4;
    logic [1:0] phase4;
    logic       fl4;
    logic [2:0] red3, yel3, grn3;
    logic [1:0] phase3;
    logic       fl3;

    exp_t sbq[$];
    exp_t prev;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    semaphore_ctrl u2 (
        .clk(clk), .res(res), .tick(tick), .dis(dis), .req(req2),
        .red(red2), .yel(yel2), .grn(grn2), .phase(phase2), .flashing(fl2)
    );

    semaphore_ctrl #(.N_PHASES(4)) u4 (
        .clk(clk), .res(res), .tick(tick), .dis(dis), .req(req4),
        .red(red4), .yel(yel4), .grn(grn4), .phase(phase4), .flashing(fl4)
    );

    semaphore_ctrl #(.N_PHASES(3), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1)) u3 (
        .clk(clk), .res(res), .tick(tick), .dis(dis), .req(req3),
        .red(red3), .yel(yel3), .grn(grn3), .phase(phase3), .flashing(fl3)
    );

    // st: 0 all-red, 1 green, 2 yellow, 3 flash lamps on, 4 flash lamps off
    function automatic exp_t mk(int sel, int st, int ph, string tag);
        exp_t e;
        logic [3:0] m;
        m     = 4'((1 << sel) - 1);
        e.sel = sel;
        e.tag = tag;
        e.r   = m;
        e.y   = '0;
        e.g   = '0;
        e.ph  = 2'(ph);
        e.fl  = (st >= 3);
        case (st)
            1: begin e.g[ph] = 1'b1; e.r[ph] = 1'b0; end
            2: begin e.y[ph] = 1'b1; e.r[ph] = 1'b0; end
            3: begin e.r = '0; e.y = m; end
            4: begin e.r = '0; e.y = '0; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        logic [14:0] act, want;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                2:       act = {4'(red2), 4'(yel2), 4'(grn2), 2'(phase2), fl2};
                4:       act = {red4, yel4, grn4, phase4, fl4};
                default: act = {4'(red3), 4'(yel3), 4'(grn3), phase3, fl3};
            endcase
            want = {e.r, e.y, e.g, e.ph, e.fl};
            nvec++;
            assert (act === want) else begin
                nmis++;
                $error("FAIL %s: observed r=%b y=%b g=%b ph=%0d fl=%b, expected r=%b y=%b g=%b ph=%0d fl=%b",
                       e.tag, act[14:11], act[10:7], act[6:3], act[2:1], act[0],
                       e.r, e.y, e.g, e.ph, e.fl);
            end
        end
    endtask

    // One clock without tick, expecting the given state.
    task automatic nt(int sel, int st, int ph, string tag);
        prev = mk(sel, st, ph, tag);
        sbq.push_back(prev);
        cyc();
    endtask

    // cpt-1 idle clocks holding the previous lamps, then a tick clock that lands on the new state.
    task automatic tk(int sel, int cpt, int st, int ph, string tag);
        for (int k = 0; k < cpt - 1; k++) begin
            sbq.push_back(prev);
            cyc();
        end
        tick = 1'b1;
        prev = mk(sel, st, ph, tag);
        sbq.push_back(prev);
        cyc();
        tick = 1'b0;
    endtask

    task automatic run(int sel, int cpt, int ph, int g, int y, int a, string tag);
        for (int i = 0; i < g; i++) tk(sel, cpt, 1, ph, {tag, "_grn"});
        for (int i = 0; i < y; i++) tk(sel, cpt, 2, ph, {tag, "_yel"});
        for (int i = 0; i < a; i++) tk(sel, cpt, 0, ph, {tag, "_allred"});
    endtask

    initial begin
        res  = 1'b1;
        tick = 1'b0;
        dis  = 1'b0;
        req2 = '0;
        req4 = '0;
        req3 = '0;

        // N=2 defaults, tick every 4 clk
        nt(2, 0, 1, "reset2");
        res = 1'b0;
        for (int c = 0; c < 2; c++) begin
            run(2, 4, 0, 5, 2, 1, "n2_ph0");
            run(2, 4, 1, 5, 2, 1, "n2_ph1");
        end
        tk(2, 4, 1, 0, "n2_wrap_grn0");
        nt(2, 1, 0, "n2_no_tick_hold");

        // maintenance mode entered mid-green without a tick
        dis = 1'b1;
        nt(2, 3, 0, "dis_enter");
        nt(2, 3, 0, "dis_hold_no_tick");
        tk(2, 2, 4, 0, "flash_off1");
        tk(2, 2, 3, 0, "flash_on1");
        tk(2, 2, 4, 0, "flash_off2");
        tk(2, 2, 3, 0, "flash_on2");
        dis = 1'b0;
        nt(2, 0, 1, "dis_exit");
        tk(2, 4, 1, 0, "dis_restart_grn0");

        // reset beats dis and tick mid-yellow
        for (int i = 0; i < 4; i++) tk(2, 4, 1, 0, "pre_res_grn");
        tk(2, 4, 2, 0, "pre_res_yel");
        res  = 1'b1;
        dis  = 1'b1;
        tick = 1'b1;
        nt(2, 0, 1, "res_beats_dis");
        res  = 1'b0;
        dis  = 1'b0;
        tick = 1'b0;
        tk(2, 4, 1, 0, "post_res_grn0");

        // N=4, only phase 3 requesting, then demand moves to phases 0 and 2
        res = 1'b1;
        nt(4, 0, 3, "reset4");
        res  = 1'b0;
        req4 = 4'b1000;
        run(4, 1, 3, 5, 2, 1, "n4_req3_a");
        run(4, 1, 3, 5, 2, 1, "n4_req3_b");
        tk(4, 1, 1, 3, "n4_req3_c_grn");
        req4 = 4'b0101;
        run(4, 1, 3, 4, 2, 1, "n4_ph3_finish");
        run(4, 1, 0, 5, 2, 1, "n4_ph0");
        tk(4, 1, 1, 2, "n4_ph2_grn");

        // N=3, one-tick states, tick every clk, wrap 2->0
        res = 1'b1;
        nt(3, 0, 2, "reset3");
        res = 1'b0;
        run(3, 1, 0, 1, 1, 1, "n3_ph0");
        run(3, 1, 1, 1, 1, 1, "n3_ph1");
        run(3, 1, 2, 1, 1, 1, "n3_ph2");
        tk(3, 1, 1, 0, "n3_wrap_grn0");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
